// File: rtl/pcs_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pcs_link_ctrl
// Purpose  : Link bring-up / retrain sequencer for the 4-lane PCS/FEC core.
//            Pulses the PCS soft reset, waits for block lock on all lanes,
//            debounces lock, then enables traffic. Lock loss or an excessive
//            receive error rate re-issues the soft reset.
// Ports    : clkcore            - core clock
//            reset_n            - asynchronous active-low reset
//            in_enable          - 1 = bring the link up, 0 = park in IDLE
//            in_block_lock[3:0] - per-lane block lock (asynchronous)
//            in_rx_valid        - receive data valid
//            in_rx_error        - receive data error (qualified by valid)
//            out_csr_reset_n    - soft reset to the PCS, active-low
//            out_tx_enable      - traffic generator enable
//            out_link_up        - high only in UP
//            out_state[2:0]     - IDLE=0 RESET=1 WAIT_LOCK=2 STABLE=3 UP=4
//            out_retrain_count  - failure-driven RESET entries, saturating
// Revision : 1.0 - initial release
// ============================================================================
module pcs_link_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 64,
  parameter int ERR_WINDOW   = 1024,
  parameter int ERR_THRESH   = 8
) (
  input  logic       clkcore,
  input  logic       reset_n,
  input  logic       in_enable,
  input  logic [3:0] in_block_lock,
  input  logic       in_rx_valid,
  input  logic       in_rx_error,
  output logic       out_csr_reset_n,
  output logic       out_tx_enable,
  output logic       out_link_up,
  output logic [2:0] out_state,
  output logic [7:0] out_retrain_count
);

  // One shared timer serves every state, so it is sized for the longest span.
  localparam int C_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int C_MAX_B = (LOCK_STABLE > ERR_WINDOW) ? LOCK_STABLE : ERR_WINDOW;
  localparam int C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_TMR_W = $clog2(C_MAX + 1);

  localparam logic [C_TMR_W-1:0] C_RST_LAST    = C_TMR_W'(RST_CYCLES - 1);
  localparam logic [C_TMR_W-1:0] C_TIMEOUT_LAST = C_TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [C_TMR_W-1:0] C_STABLE_LAST = C_TMR_W'(LOCK_STABLE - 1);
  localparam logic [C_TMR_W-1:0] C_WIN_LAST    = C_TMR_W'(ERR_WINDOW - 1);
  localparam logic [31:0]        C_ERR_THRESH  = 32'(ERR_THRESH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_UP        = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [C_TMR_W-1:0]   timer_q, timer_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [7:0]           retrain_q, retrain_d;
  logic                 csr_reset_n_q, csr_reset_n_d;
  logic                 tx_enable_q, tx_enable_d;
  logic                 link_up_q, link_up_d;
  logic [3:0]           sync1_q, sync2_q;

  logic                 lock;
  logic                 cur_err;
  logic [8:0]           err_sum;
  logic                 retrain_hit;

  // Per-lane two-flop synchronizers; each bit is an independent chain.
  always_ff @(posedge clkcore or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
    end else begin
      sync1_q <= in_block_lock;
      sync2_q <= sync1_q;
    end
  end

  assign lock    = &sync2_q;
  assign cur_err = in_rx_valid & in_rx_error;
  // The current cycle's error is included before comparing with the threshold.
  assign err_sum = {1'b0, err_cnt_q} + {8'd0, cur_err};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    err_cnt_d   = err_cnt_q;
    retrain_hit = 1'b0;

    if (!in_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
        end
        ST_RESET: begin
          if (timer_q == C_RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // Lock takes precedence over an expiring timeout.
          if (lock) begin
            state_d = ST_STABLE;
          end else if (timer_q == C_TIMEOUT_LAST) begin
            state_d     = ST_RESET;
            retrain_hit = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == C_STABLE_LAST) begin
            state_d = ST_UP;
          end
        end
        ST_UP: begin
          // Lock loss and error threshold share one retrain increment.
          if (!lock || ({23'd0, err_sum} >= C_ERR_THRESH)) begin
            state_d     = ST_RESET;
            retrain_hit = 1'b1;
          end else if (timer_q == C_WIN_LAST) begin
            timer_d   = '0;
            err_cnt_d = 8'd0;
          end else begin
            err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Every state entry (and parking in IDLE) restarts timer and error count.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      timer_d   = '0;
      err_cnt_d = 8'd0;
    end

    retrain_d = (retrain_hit && (retrain_q != 8'hFF)) ? retrain_q + 8'd1 : retrain_q;

    // Outputs are registered from the next state so they track out_state.
    csr_reset_n_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                    (state_d == ST_UP);
    tx_enable_d   = (state_d == ST_UP);
    link_up_d     = (state_d == ST_UP);
  end

  always_ff @(posedge clkcore or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      err_cnt_q     <= 8'd0;
      retrain_q     <= 8'd0;
      csr_reset_n_q <= 1'b0;
      tx_enable_q   <= 1'b0;
      link_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      err_cnt_q     <= err_cnt_d;
      retrain_q     <= retrain_d;
      csr_reset_n_q <= csr_reset_n_d;
      tx_enable_q   <= tx_enable_d;
      link_up_q     <= link_up_d;
    end
  end

  assign out_state         = state_q;
  assign out_csr_reset_n   = csr_reset_n_q;
  assign out_tx_enable     = tx_enable_q;
  assign out_link_up       = link_up_q;
  assign out_retrain_count = retrain_q;

endmodule
`default_nettype wire

// File: tb/tb_pcs_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_link_ctrl
// Purpose  : Self-checking bench for pcs_link_ctrl. A cycle model derived from
//            the link rules is compared with the DUT on every falling edge;
//            directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_link_ctrl;

  localparam int P_RST    = 16;
  localparam int P_TO     = 64;
  localparam int P_STABLE = 64;
  localparam int P_WIN    = 32;
  localparam int P_THRESH = 8;

  logic       clkcore = 1'b0;
  logic       reset_n;
  logic       in_enable;
  logic [3:0] in_block_lock;
  logic       in_rx_valid;
  logic       in_rx_error;
  logic       out_csr_reset_n;
  logic       out_tx_enable;
  logic       out_link_up;
  logic [2:0] out_state;
  logic [7:0] out_retrain_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clkcore = ~clkcore;

  pcs_link_ctrl #(
    .RST_CYCLES  (P_RST),
    .LOCK_TIMEOUT(P_TO),
    .LOCK_STABLE (P_STABLE),
    .ERR_WINDOW  (P_WIN),
    .ERR_THRESH  (P_THRESH)
  ) dut (
    .clkcore          (clkcore),
    .reset_n          (reset_n),
    .in_enable        (in_enable),
    .in_block_lock    (in_block_lock),
    .in_rx_valid      (in_rx_valid),
    .in_rx_error      (in_rx_error),
    .out_csr_reset_n  (out_csr_reset_n),
    .out_tx_enable    (out_tx_enable),
    .out_link_up      (out_link_up),
    .out_state        (out_state),
    .out_retrain_count(out_retrain_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 reset pulse, 2 waiting for lock, 3 debounce, 4 up
  int       m_phase, m_elapsed, m_errs, m_retrains, m_next;
  bit       m_fail_event, m_lock, m_err_now;
  bit [3:0] m_lock_dly [2];   // raw lock seen 1 and 2 edges ago

  always @(posedge clkcore or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_elapsed = 0; m_errs = 0; m_retrains = 0;
      m_lock_dly[0] = 4'h0; m_lock_dly[1] = 4'h0;
    end else begin
      m_lock       = (m_lock_dly[1] == 4'hF);
      m_err_now    = in_rx_valid && in_rx_error;
      m_next       = m_phase;
      m_fail_event = 0;
      if (!in_enable) m_next = 0;
      else if (m_phase == 0) m_next = 1;
      else if (m_phase == 1) begin
        if (m_elapsed + 1 == P_RST) m_next = 2;
      end else if (m_phase == 2) begin
        if (m_lock) m_next = 3;
        else if (m_elapsed + 1 == P_TO) begin m_next = 1; m_fail_event = 1; end
      end else if (m_phase == 3) begin
        if (!m_lock) m_next = 2;
        else if (m_elapsed + 1 == P_STABLE) m_next = 4;
      end else begin
        if (!m_lock || (m_errs + int'(m_err_now) >= P_THRESH)) begin
          m_next = 1; m_fail_event = 1;
        end
      end

      if (m_next != m_phase) begin
        m_elapsed = 0; m_errs = 0;
      end else if (m_phase == 4) begin
        if (m_elapsed == P_WIN - 1) begin
          m_elapsed = 0; m_errs = 0;
        end else begin
          m_elapsed++;
          m_errs = (m_errs + int'(m_err_now) > 255) ? 255 : m_errs + int'(m_err_now);
        end
      end else begin
        m_elapsed++;
      end

      if (m_fail_event) m_retrains = (m_retrains >= 255) ? 255 : m_retrains + 1;
      m_phase       = m_next;
      m_lock_dly[1] = m_lock_dly[0];
      m_lock_dly[0] = in_block_lock;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clkcore) begin
    check("state",       int'(out_state),         m_phase);
    check("csr_reset_n", int'(out_csr_reset_n),   (m_phase >= 2) ? 1 : 0);
    check("tx_enable",   int'(out_tx_enable),     (m_phase == 4) ? 1 : 0);
    check("link_up",     int'(out_link_up),       (m_phase == 4) ? 1 : 0);
    check("retrain_cnt", int'(out_retrain_count), m_retrains);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic en, input logic [3:0] lk, input logic v, input logic e);
    @(negedge clkcore);
    in_enable = en; in_block_lock = lk; in_rx_valid = v; in_rx_error = e;
    @(posedge clkcore);
    #1;
  endtask

  task automatic wait_state(input int target, input int budget, input logic [3:0] lk,
                            output int n);
    n = 0;
    while ((int'(out_state) != target) && (n < budget)) begin
      cyc(1'b1, lk, 1'b0, 1'b0);
      n++;
    end
    check($sformatf("reach_state_%0d", target), int'(out_state), target);
  endtask

  int n_wait;
  int retr_before;

  initial begin
    reset_n = 1'b0; in_enable = 1'b0; in_block_lock = 4'hF;
    in_rx_valid = 1'b0; in_rx_error = 1'b0;
    repeat (3) @(posedge clkcore);
    #1;
    check("rst_state",  int'(out_state), 0);
    check("rst_csr",    int'(out_csr_reset_n), 0);
    check("rst_tx",     int'(out_tx_enable), 0);
    check("rst_retrain", int'(out_retrain_count), 0);
    @(negedge clkcore); reset_n = 1'b1;
    repeat (3) cyc(1'b0, 4'hF, 1'b0, 1'b0);

    // Basic bring-up: 82 edges from enable to traffic.
    for (int k = 1; k <= 82; k++) begin
      cyc(1'b1, 4'hF, 1'b0, 1'b0);
      if (k == 1)  check("bu_e1_state", int'(out_state), 1);
      if (k == 16) check("bu_e16_csr", int'(out_csr_reset_n), 0);
      if (k == 17) begin
        check("bu_e17_state", int'(out_state), 2);
        check("bu_e17_csr", int'(out_csr_reset_n), 1);
      end
      if (k == 18) check("bu_e18_state", int'(out_state), 3);
      if (k == 81) check("bu_e81_tx", int'(out_tx_enable), 0);
      if (k == 82) begin
        check("bu_e82_tx", int'(out_tx_enable), 1);
        check("bu_e82_state", int'(out_state), 4);
        check("bu_retrain", int'(out_retrain_count), 0);
      end
    end

    // Error windows: 7 + wrap + 7 is fine; 8 with the last on the wrap cycle fails.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < P_WIN; i++) begin
        if (w == 0)      cyc(1'b1, 4'hF, 1'b1, i < 7);
        else if (w == 1) cyc(1'b1, 4'hF, !(i >= 20 && i <= 25), (i < 7) || (i >= 20 && i <= 25));
        else             cyc(1'b1, 4'hF, 1'b1, i >= 24);
      end
      if (w == 1) begin
        check("err_7_7_state", int'(out_state), 4);
        check("err_7_7_retrain", int'(out_retrain_count), 0);
      end
    end
    check("err_8_state", int'(out_state), 1);
    check("err_8_retrain", int'(out_retrain_count), 1);

    // STABLE debounce: one-cycle lock glitch restarts WAIT_LOCK without retrain.
    wait_state(3, 100, 4'hF, n_wait);
    repeat (40) cyc(1'b1, 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    wait_state(2, 10, 4'hF, n_wait);
    check("deb_retrain", int'(out_retrain_count), 1);
    wait_state(4, 200, 4'hF, n_wait);
    check("deb_cycles_to_up", n_wait, 65);

    // Lock loss coinciding with the 8th error: single increment.
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'hF, 1'b1, 1'b1);
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    check("sim_pre_state", int'(out_state), 4);
    cyc(1'b1, 4'hF, 1'b1, 1'b1);
    check("sim_state", int'(out_state), 1);
    check("sim_retrain", int'(out_retrain_count), 2);

    // in_enable low during RESET.
    repeat (3) cyc(1'b1, 4'hF, 1'b0, 1'b0);
    cyc(1'b0, 4'hF, 1'b0, 1'b0);
    check("dis_state", int'(out_state), 0);
    check("dis_csr", int'(out_csr_reset_n), 0);
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    check("reen_state", int'(out_state), 1);
    check("dis_retrain", int'(out_retrain_count), 2);

    // Lock timeout and saturation.
    wait_state(2, 40, 4'h7, n_wait);
    repeat (P_TO - 1) cyc(1'b1, 4'h7, 1'b0, 1'b0);
    check("to_still_wait", int'(out_state), 2);
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    check("to_state", int'(out_state), 1);
    check("to_retrain", int'(out_retrain_count), 3);
    repeat (256 * (P_RST + P_TO)) cyc(1'b1, 4'h7, 1'b0, 1'b0);
    check("sat_retrain", int'(out_retrain_count), 255);

    // Asynchronous reset while UP.
    wait_state(4, 200, 4'hF, n_wait);
    @(negedge clkcore);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", int'(out_state), 0);
    check("arst_csr", int'(out_csr_reset_n), 0);
    check("arst_tx", int'(out_tx_enable), 0);
    check("arst_link", int'(out_link_up), 0);
    check("arst_retrain", int'(out_retrain_count), 0);
    #1 reset_n = 1'b1;
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    check("arst_restart", int'(out_state), 1);
    wait_state(4, 200, 4'hF, n_wait);
    check("arst_link_up", int'(out_link_up), 1);
    check("arst_final_retrain", int'(out_retrain_count), 0);

    @(negedge clkcore);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
